data_mem_write_buffer: RTL and testbench
========================================

DATA_MEM_WRITE_BUFFER -- requirements
Module: data_mem_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the store-buffer entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the word-address width; the RAM holds 2^ADDR_WIDTH words.
REQ-003 Parameter WORD_WIDTH, default 32, SHALL set the data word width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 clk_enable  input  1  SHALL gate every state update; when low, no register, pointer, flag or RAM word changes.
REQ-007 i_read_address  input  ADDR_WIDTH  SHALL be the CPU memory-stage load address.
REQ-008 o_read_data  output  WORD_WIDTH  SHALL be the combinational load result, valid in the same cycle.
REQ-009 i_write_address  input  ADDR_WIDTH  SHALL be the CPU store address.
REQ-010 i_write_data  input  WORD_WIDTH  SHALL be the CPU store data.
REQ-011 i_write_enable  input  1  SHALL request a store push.
REQ-012 i_dbg_write_enable, i_dbg_write_address, i_dbg_write_data  input  1/ADDR_WIDTH/WORD_WIDTH  SHALL form a loader port that writes RAM directly.
REQ-013 o_full  output  1  SHALL be high when the buffer holds DEPTH entries.
REQ-014 o_empty  output  1  SHALL be high when the buffer holds 0 entries.
REQ-015 o_overflow  output  1  SHALL be the sticky flag for a dropped store.
REQ-016 o_mmio_out  output  WORD_WIDTH  SHALL be the memory-mapped output register.

Function
REQ-017 The buffer SHALL be a circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count from 0 to DEPTH.
REQ-018 Push: on a clk_enable edge with i_write_enable high and o_full low, the block SHALL write {address, data} at the tail and advance the tail.
REQ-019 Drain: on a clk_enable edge with o_empty low and i_dbg_write_enable low, the block SHALL write the head entry to RAM and advance the head; at most one drain per cycle.
REQ-020 Debug priority: a debug write SHALL take the RAM write port that cycle, stalling the drain; a buffered store to the same address that drains later SHALL overwrite the debug data.
REQ-021 Simultaneous push and drain SHALL leave the count unchanged.
REQ-022 A push while full SHALL be accepted only if a drain occurs on the same edge; otherwise the store is dropped and o_overflow is set to 1 until reset.
REQ-023 o_read_data SHALL return the data of the youngest valid buffer entry whose address equals i_read_address, else RAM[i_read_address].
REQ-024 A store pushed in cycle N SHALL be visible to a load from cycle N+1 onward, through forwarding.
REQ-025 o_full and o_empty SHALL be registered-state decodes of the count, with no combinational path from i_write_enable.
REQ-026 Latency: an entry pushed into an empty buffer SHALL reach RAM on the next clk_enable edge that has no debug write.

Reset
REQ-027 While rst_n is low: count = 0, head = tail = 0, o_empty = 1, o_full = 0, o_overflow = 0, o_mmio_out = 0.
REQ-028 RAM contents SHALL NOT be reset; buffered entries lost by reset mid-operation SHALL never reach RAM.
REQ-029 Reset deassertion SHALL take effect on the first clk_enable edge after rst_n rises.

Configuration
REQ-030 With macro DATA_MEM_MMIO_EN defined, a drain to address all-ones-minus-3 (8'hFC at default width) SHALL update o_mmio_out instead of RAM, and loads from that address SHALL return o_mmio_out unless forwarded.
REQ-031 Without DATA_MEM_MMIO_EN, that address SHALL be ordinary RAM and o_mmio_out SHALL be held at 0.

Verification
REQ-032 After reset, push store (0x10, 0xDEADBEEF), then load 0x10 next cycle -> o_read_data = 0xDEADBEEF before and after the drain; o_empty returns to 1.
REQ-033 Push two stores to 0x20 (0x1 then 0x2), then load 0x20 -> 0x2 from forwarding; after both drain, RAM[0x20] = 0x2.
REQ-034 Hold i_dbg_write_enable high and push 5 stores with DEPTH=4 -> o_full = 1 after the 4th push, the 5th is dropped, o_overflow = 1; release debug and the 4 stores drain in order.
REQ-035 Full buffer, push and drain on the same edge -> push accepted, count stays 4, o_overflow stays 0.
REQ-036 Assert rst_n low with 3 entries pending -> o_empty = 1 immediately; the pending addresses keep their old RAM values.
REQ-037 With DATA_MEM_MMIO_EN, store 0xA5 to 0xFC -> o_mmio_out = 0xA5 after the drain; without the macro, RAM[0xFC] = 0xA5 and o_mmio_out = 0.

Source files
------------

// File: rtl/data_mem_write_buffer_if.sv
// CPU-side bus of the data-memory store buffer: load port, store port, loader port and status.
// The master modport is the CPU/loader side and the slave modport is the buffer side.
interface data_mem_write_buffer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] i_read_address;
    logic [WORD_WIDTH-1:0] o_read_data;
    logic [ADDR_WIDTH-1:0] i_write_address;
    logic [WORD_WIDTH-1:0] i_write_data;
    logic                  i_write_enable;
    logic                  i_dbg_write_enable;
    logic [ADDR_WIDTH-1:0] i_dbg_write_address;
    logic [WORD_WIDTH-1:0] i_dbg_write_data;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_overflow;
    logic [WORD_WIDTH-1:0] o_mmio_out;

    modport master (
        output i_read_address, i_write_address, i_write_data, i_write_enable,
               i_dbg_write_enable, i_dbg_write_address, i_dbg_write_data,
        input  o_read_data, o_full, o_empty, o_overflow, o_mmio_out
    );

    modport slave (
        input  i_read_address, i_write_address, i_write_data, i_write_enable,
               i_dbg_write_enable, i_dbg_write_address, i_dbg_write_data,
        output o_read_data, o_full, o_empty, o_overflow, o_mmio_out
    );
endinterface

// File: rtl/data_mem_write_buffer.sv
// Data RAM fronted by a DEPTH-entry store FIFO with load forwarding and a loader port.
// Optional DATA_MEM_MMIO_EN maps the word at all-ones-minus-3 to the o_mmio_out register.
module data_mem_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_enable,
    data_mem_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic [ADDR_WIDTH-1:0] r_buf_addr [DEPTH];
    logic [WORD_WIDTH-1:0] r_buf_data [DEPTH];
    logic [WORD_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    logic                  w_full;
    logic                  w_empty;
    logic                  w_drain;
    logic                  w_push;
    logic                  w_drop;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [WORD_WIDTH-1:0] w_head_data;
    logic                  w_to_mmio;
    logic [WORD_WIDTH-1:0] w_ram_rdata;
    logic                  w_fwd_hit;
    logic [WORD_WIDTH-1:0] w_fwd_data;
    logic [PTR_W-1:0]      w_idx;

    // Flags decode the count register only, so i_write_enable never reaches them.
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_drain     = clk_enable && !w_empty && !bus.i_dbg_write_enable;
    assign w_push      = clk_enable && bus.i_write_enable && (!w_full || w_drain);
    assign w_drop      = clk_enable && bus.i_write_enable && w_full && !w_drain;
    assign w_head_addr = r_buf_addr[r_head];
    assign w_head_data = r_buf_data[r_head];

    assign bus.o_full     = w_full;
    assign bus.o_empty    = w_empty;
    assign bus.o_overflow = r_overflow;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clk_enable) begin
            if (w_push)  r_tail <= r_tail + 1'b1;
            if (w_drain) r_head <= r_head + 1'b1;
            if (w_push && !w_drain)      r_count <= r_count + 1'b1;
            else if (w_drain && !w_push) r_count <= r_count - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // NOTE: entry payloads and RAM words carry no reset; validity comes from r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_addr[r_tail] <= bus.i_write_address;
            r_buf_data[r_tail] <= bus.i_write_data;
        end
    end

`ifdef DATA_MEM_MMIO_EN
    localparam logic [ADDR_WIDTH-1:0] MMIO_ADDR = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(3);
    logic [WORD_WIDTH-1:0] r_mmio_out;

    assign w_to_mmio = (w_head_addr == MMIO_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_mmio_out <= '0;
        else if (w_drain && w_to_mmio) r_mmio_out <= w_head_data;
    end

    assign w_ram_rdata    = (bus.i_read_address == MMIO_ADDR) ? r_mmio_out
                                                               : r_mem[bus.i_read_address];
    assign bus.o_mmio_out = r_mmio_out;
`else
    assign w_to_mmio      = 1'b0;
    assign w_ram_rdata    = r_mem[bus.i_read_address];
    assign bus.o_mmio_out = '0;
`endif

    // Loader owns the write port when active; the drain simply waits a cycle.
    always_ff @(posedge clk) begin
        if (clk_enable) begin
            if (bus.i_dbg_write_enable)   r_mem[bus.i_dbg_write_address] <= bus.i_dbg_write_data;
            else if (w_drain && !w_to_mmio) r_mem[w_head_addr] <= w_head_data;
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_buf_addr[w_idx] == bus.i_read_address)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_buf_data[w_idx];
            end
        end
    end

    assign bus.o_read_data = w_fwd_hit ? w_fwd_data : w_ram_rdata;
endmodule

// File: tb/tb_data_mem_write_buffer.sv
// Directed bench for data_mem_write_buffer: forwarding, drain order, full/overflow, reset, gating, MMIO.
module tb_data_mem_write_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_enable = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;

    data_mem_write_buffer_if #(.ADDR_WIDTH(8), .WORD_WIDTH(32)) bus ();

    data_mem_write_buffer #(.DEPTH(4), .ADDR_WIDTH(8), .WORD_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.i_read_address      = '0;
        bus.i_write_address     = '0;
        bus.i_write_data        = '0;
        bus.i_write_enable      = 1'b0;
        bus.i_dbg_write_enable  = 1'b0;
        bus.i_dbg_write_address = '0;
        bus.i_dbg_write_data    = '0;
    endtask

    task automatic dbg_wr(input logic [7:0] a, input logic [31:0] d);
        bus.i_dbg_write_enable  = 1'b1;
        bus.i_dbg_write_address = a;
        bus.i_dbg_write_data    = d;
        tick();
        bus.i_dbg_write_enable  = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d);
        bus.i_write_enable  = 1'b1;
        bus.i_write_address = a;
        bus.i_write_data    = d;
        tick();
        bus.i_write_enable  = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.i_read_address = a;
        #1;
        check(tag, bus.o_read_data, exp);
    endtask

    logic [7:0]  c_addr [5] = '{8'h60, 8'h61, 8'h60, 8'h61, 8'h62};
    logic [31:0] c_data [5] = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};

    initial begin
        idle();
        #1;
        check("rst_empty",    32'(bus.o_empty),    32'd1);
        check("rst_full",     32'(bus.o_full),     32'd0);
        check("rst_overflow", 32'(bus.o_overflow), 32'd0);
        check("rst_mmio",     bus.o_mmio_out,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        dbg_wr(8'h10, 32'h0);
        dbg_wr(8'h20, 32'h0);
        dbg_wr(8'h30, 32'h30);
        dbg_wr(8'h31, 32'h31);
        dbg_wr(8'h32, 32'h32);
        dbg_wr(8'h62, 32'h0);

        // single store, forwarded then drained
        bus.i_write_enable  = 1'b1;
        bus.i_write_address = 8'h10;
        bus.i_write_data    = 32'hDEADBEEF;
        #1;
        check("a_empty_no_comb", 32'(bus.o_empty), 32'd1);
        tick();
        bus.i_write_enable = 1'b0;
        read_chk("a_fwd", 8'h10, 32'hDEADBEEF);
        check("a_empty_pending", 32'(bus.o_empty), 32'd0);
        tick();
        read_chk("a_ram", 8'h10, 32'hDEADBEEF);
        check("a_empty_after", 32'(bus.o_empty), 32'd1);

        // two stores to one address
        push(8'h20, 32'h1);
        push(8'h20, 32'h2);
        read_chk("b_fwd", 8'h20, 32'h2);
        tick();
        read_chk("b_ram", 8'h20, 32'h2);
        check("b_empty", 32'(bus.o_empty), 32'd1);

        // loader holds the port: buffer fills, fifth store dropped
        bus.i_dbg_write_enable  = 1'b1;
        bus.i_dbg_write_address = 8'h50;
        bus.i_dbg_write_data    = 32'h55;
        for (int i = 0; i < 5; i++) begin
            bus.i_write_enable  = 1'b1;
            bus.i_write_address = c_addr[i];
            bus.i_write_data    = c_data[i];
            tick();
            if (i == 3) begin
                check("c_full4", 32'(bus.o_full), 32'd1);
                check("c_ovf4",  32'(bus.o_overflow), 32'd0);
            end
        end
        bus.i_write_enable = 1'b0;
        check("c_full5", 32'(bus.o_full), 32'd1);
        check("c_ovf5",  32'(bus.o_overflow), 32'd1);
        read_chk("c_fwd_young", 8'h60, 32'hC);
        bus.i_dbg_write_enable = 1'b0;
        tick();
        check("c_full_drain1", 32'(bus.o_full), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("c_empty", 32'(bus.o_empty), 32'd1);
        read_chk("c_ram60", 8'h60, 32'hC);
        read_chk("c_ram61", 8'h61, 32'hD);
        read_chk("c_ram62", 8'h62, 32'h0);
        read_chk("c_ram50", 8'h50, 32'h55);
        check("c_ovf_sticky", 32'(bus.o_overflow), 32'd1);

        rst_n = 1'b0;
        #1;
        check("r_ovf_clear", 32'(bus.o_overflow), 32'd0);
        tick();
        rst_n = 1'b1;

        // full buffer, push and drain on the same edge
        bus.i_dbg_write_enable  = 1'b1;
        bus.i_dbg_write_address = 8'h51;
        bus.i_dbg_write_data    = 32'h1;
        for (int i = 0; i < 4; i++) push(8'h70 + 8'(i), 32'h700 + 32'(i));
        check("d_full", 32'(bus.o_full), 32'd1);
        bus.i_dbg_write_enable = 1'b0;
        push(8'h74, 32'h774);
        check("d_full_keep", 32'(bus.o_full), 32'd1);
        check("d_ovf",       32'(bus.o_overflow), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("d_empty", 32'(bus.o_empty), 32'd1);
        read_chk("d_ram70", 8'h70, 32'h700);
        read_chk("d_ram74", 8'h74, 32'h774);

        // reset with pending entries
        bus.i_dbg_write_enable  = 1'b1;
        bus.i_dbg_write_address = 8'h52;
        bus.i_dbg_write_data    = 32'h2;
        for (int i = 0; i < 3; i++) push(8'h30 + 8'(i), 32'hBAD0 + 32'(i));
        read_chk("e_fwd", 8'h31, 32'hBAD1);
        rst_n = 1'b0;
        #1;
        check("e_empty_async", 32'(bus.o_empty), 32'd1);
        bus.i_dbg_write_enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        read_chk("e_ram30", 8'h30, 32'h30);
        read_chk("e_ram31", 8'h31, 32'h31);
        read_chk("e_ram32", 8'h32, 32'h32);

        // clk_enable low freezes everything
        clk_enable = 1'b0;
        bus.i_dbg_write_enable  = 1'b1;
        bus.i_dbg_write_address = 8'h30;
        bus.i_dbg_write_data    = 32'hFFFF;
        push(8'h80, 32'h1);
        idle();
        check("f_empty", 32'(bus.o_empty), 32'd1);
        read_chk("f_ram30", 8'h30, 32'h30);
        clk_enable = 1'b1;

        // loader and store hit the same address
        bus.i_dbg_write_enable  = 1'b1;
        bus.i_dbg_write_address = 8'h90;
        bus.i_dbg_write_data    = 32'h1111;
        push(8'h90, 32'h2222);
        idle();
        read_chk("g_fwd", 8'h90, 32'h2222);
        check("g_stalled", 32'(bus.o_empty), 32'd0);
        tick();
        read_chk("g_ram", 8'h90, 32'h2222);
        check("g_empty", 32'(bus.o_empty), 32'd1);

        push(8'hFC, 32'hA5);
        check("h_mmio_pre", bus.o_mmio_out, 32'd0);
        tick();
`ifdef DATA_MEM_MMIO_EN
        check("h_mmio", bus.o_mmio_out, 32'hA5);
`else
        check("h_mmio_zero", bus.o_mmio_out, 32'd0);
`endif
        read_chk("h_read_fc", 8'hFC, 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
